// File: rtl/binary_to_ascii_tx.sv
// Binary-to-decimal ASCII streamer: double-dabble conversion, then valid/ready byte output.
// Define BIN2ASCII_CRLF_EN to append CR, LF after the last digit.
module binary_to_ascii_tx #(
    parameter int NUM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NUM_W-1:0] value,
    input  logic             start,
    output logic             busy,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             done
);

    localparam int DIGITS = (NUM_W * 301 + 999) / 1000;
    localparam int BCD_W  = DIGITS * 4;
    localparam int DD_W   = BCD_W + NUM_W;
    localparam int PTR_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W  = (NUM_W > 1) ? $clog2(NUM_W) : 1;

`ifdef BIN2ASCII_CRLF_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_SEND,
        S_TERM
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_SEND
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [NUM_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               done_q, done_d;
`ifdef BIN2ASCII_CRLF_EN
    logic               term_lf_q, term_lf_d;
`endif

    logic [BCD_W-1:0]   bcd_adj;
    logic [DD_W-1:0]    dd_next;
    logic [BCD_W-1:0]   bcd_shift;
    logic [NUM_W-1:0]   shift_shift;
    logic [PTR_W-1:0]   msd_ptr;

    // One double-dabble step: add 3 to every nibble >= 5, then shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end else begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4];
            end
        end
        dd_next     = {bcd_adj, shift_q} << 1;
        bcd_shift   = dd_next[DD_W-1:NUM_W];
        shift_shift = dd_next[NUM_W-1:0];
    end

    // Highest nonzero digit of the final BCD; zero value lands on digit 0.
    always_comb begin
        msd_ptr = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_shift[i*4 +: 4] != 4'd0) begin
                msd_ptr = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        done_d     = 1'b0;
`ifdef BIN2ASCII_CRLF_EN
        term_lf_d  = term_lf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = value;
                    bcd_d   = '0;
                    ptr_d   = '0;
                    cnt_d   = CNT_W'(NUM_W - 1);
                    busy_d  = 1'b1;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                shift_d = shift_shift;
                bcd_d   = bcd_shift;
                if (cnt_q == '0) begin
                    ptr_d      = msd_ptr;
                    tx_data_d  = {4'h3, bcd_shift[4*int'(msd_ptr) +: 4]};
                    tx_valid_d = 1'b1;
                    state_d    = S_SEND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (ptr_q == '0) begin
`ifdef BIN2ASCII_CRLF_EN
                        tx_data_d = 8'h0D;
                        term_lf_d = 1'b0;
                        state_d   = S_TERM;
`else
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
`endif
                    end else begin
                        ptr_d     = ptr_q - PTR_W'(1);
                        tx_data_d = {4'h3, bcd_q[4*(int'(ptr_q)-1) +: 4]};
                    end
                end
            end
`ifdef BIN2ASCII_CRLF_EN
            S_TERM: begin
                if (tx_ready) begin
                    if (!term_lf_q) begin
                        tx_data_d = 8'h0A;
                        term_lf_d = 1'b1;
                    end else begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        term_lf_d  = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            done_q     <= 1'b0;
`ifdef BIN2ASCII_CRLF_EN
            term_lf_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
`ifdef BIN2ASCII_CRLF_EN
            term_lf_q  <= term_lf_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign done     = done_q;

endmodule

// File: tb/tb_binary_to_ascii_tx.sv
// Bench for binary_to_ascii_tx: directed and random values against a
// decimal-string reference model, with varied sink back-pressure.
module tb_binary_to_ascii_tx;

    localparam int NUM_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NUM_W-1:0] value = '0;
    logic             start = 1'b0;
    logic             busy;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    binary_to_ascii_tx #(.NUM_W(NUM_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .start    (start),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected byte stream: decimal text of v, MSD first, no leading zeros.
    task automatic build_exp(input int unsigned v);
        int unsigned r;
        exp_q.delete();
        r = v;
        if (r == 0) exp_q.push_back(8'h30);
        while (r > 0) begin
            exp_q.push_front(8'(8'h30 + r % 10));
            r = r / 10;
        end
`ifdef BIN2ASCII_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    // mode 0: ready tied high, 1: ready one cycle in three, 2: random ready
    task automatic run(input logic [NUM_W-1:0] v, input int mode,
                       input bit restart, input logic [NUM_W-1:0] rv);
        int cyc;
        int idx;
        bit stall;
        bit first;
        bit fin;
        bit rdy;
        logic [7:0] pdata;
        build_exp(v);
        @(negedge clk);
        value = v;
        start = 1'b1;
        tx_ready = (mode == 0);
        @(negedge clk);
        start = 1'b0;
        value = NUM_W'($urandom);
        cyc = 1;
        idx = 0;
        stall = 0;
        first = 1;
        fin = 0;
        pdata = '0;
        chk("busy_after_start", busy, 1);
        for (int t = 0; t < 400 && !fin; t++) begin
            chk("busy_held", busy, 1);
            chk("no_early_done", done, 0);
            if (stall) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, pdata);
            end
            if (tx_valid && first) begin
                first = 0;
                chk("first_valid_cycle", cyc, NUM_W + 1);
            end
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 3 == 0);
            else rdy = 1'($urandom_range(0, 1));
            tx_ready = rdy;
            if (restart && idx == 1 && tx_valid) begin
                start = 1'b1;
                value = rv;
            end else begin
                start = 1'b0;
            end
            if (tx_valid && rdy) begin
                chk("byte", tx_data, exp_q[idx]);
                if (mode == 0) chk("cadence", cyc, NUM_W + 1 + idx);
                idx++;
                if (idx == exp_q.size()) fin = 1;
            end
            stall = tx_valid && !rdy;
            pdata = tx_data;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!fin) begin
            chk("timeout", 0, 1);
        end else begin
            chk("done_pulse", done, 1);
            chk("busy_clear", busy, 0);
            chk("valid_clear", tx_valid, 0);
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("idle_valid", tx_valid, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_data", tx_data, 8'h00);
        rst_n = 1'b1;

        run(16'd1234, 0, 0, '0);
        run(16'd0, 0, 0, '0);
        run(16'd65535, 1, 0, '0);
        run(16'd1005, 0, 0, '0);
        run(16'd50, 2, 0, '0);
        run(16'd4321, 0, 1, 16'd9876);
        run(16'd8765, 1, 1, 16'd3);

        // Reset in the middle of the second byte of 4321
        @(negedge clk);
        value = 16'd4321;
        start = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(negedge clk);
        chk("mid_send_valid", tx_valid, 1);
        chk("mid_send_byte2", tx_data, 8'h33);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", tx_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_data", tx_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run(16'd7, 0, 0, '0);

        for (int k = 0; k < 10; k++) begin
            logic [NUM_W-1:0] rvv;
            if (k % 2 == 0) rvv = NUM_W'($urandom_range(0, 65535));
            else rvv = NUM_W'($urandom_range(0, 120));
            run(rvv, int'($urandom_range(0, 2)), 0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
